// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: CPU instruction/data, host and ideal-memory signals of the arbiter.
interface cpu_mem_arbiter_if #(parameter int MEM_ADDR_WIDTH = 12);
  logic [31:0] PC;
  logic Inst_Req_Valid;
  logic Inst_Req_Ready;
  logic [31:0] Instruction;
  logic Inst_Valid;
  logic Inst_Ready;
  logic [31:0] Address;
  logic MemWrite;
  logic MemRead;
  logic [31:0] Write_data;
  logic [3:0] Write_strb;
  logic Mem_Req_Ready;
  logic [31:0] Read_data;
  logic Read_data_Valid;
  logic Read_data_Ready;
  logic [MEM_ADDR_WIDTH-3:0] host_addr;
  logic host_rden;
  logic host_wren;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic host_rvalid;
  logic [MEM_ADDR_WIDTH-3:0] mem_addr;
  logic mem_wren;
  logic [31:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_rden;
  logic [31:0] mem_rdata;
  modport slave (
    input PC, Inst_Req_Valid, Inst_Ready, Address, MemWrite, MemRead, Write_data, Write_strb,
          Read_data_Ready, host_addr, host_rden, host_wren, host_wdata, mem_rdata,
    output Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data, Read_data_Valid,
           host_rdata, host_rvalid, mem_addr, mem_wren, mem_wdata, mem_wstrb, mem_rden
  );
  modport master (
    output PC, Inst_Req_Valid, Inst_Ready, Address, MemWrite, MemRead, Write_data, Write_strb,
           Read_data_Ready, host_addr, host_rden, host_wren, host_wdata, mem_rdata,
    input Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data, Read_data_Valid,
          host_rdata, host_rvalid, mem_addr, mem_wren, mem_wdata, mem_wstrb, mem_rden
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: arbitrates CPU data/instruction and host accesses onto one ideal memory.
// Define ARB_ROUND_ROBIN_EN to alternate data/instruction priority (host always lowest).
module cpu_mem_arbiter #(parameter int MEM_ADDR_WIDTH = 12) (
  input logic clk,
  input logic rst,
  cpu_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESP_INST, RESP_DATA, RESP_HOST} state_t;
  state_t state_q, state_d, state_n;
  logic [31:0] rdata_q, rdata_d;
  logic idle, cpu_data, cpu_inst, host_req, inst_first;
  logic gnt_data, gnt_inst, gnt_host, is_wr, rd_gnt;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.Address[31:MEM_ADDR_WIDTH], bus.Address[1:0],
                              bus.PC[31:MEM_ADDR_WIDTH], bus.PC[1:0]};
`ifdef ARB_ROUND_ROBIN_EN
  logic prefer_inst_q, prefer_inst_d;
  assign inst_first = prefer_inst_q;
  always_comb prefer_inst_d = gnt_data ? 1'b1 : gnt_inst ? 1'b0 : prefer_inst_q;
  always_ff @(posedge clk)
    if (rst) prefer_inst_q <= 1'b0;
    else prefer_inst_q <= prefer_inst_d;
`else
  assign inst_first = 1'b0;
`endif
  always_comb begin
    idle = state_q == IDLE;
    // CPU requests are invisible during reset; host traffic still flows
    cpu_data = !rst && (bus.MemRead || bus.MemWrite);
    cpu_inst = !rst && bus.Inst_Req_Valid;
    host_req = bus.host_rden || bus.host_wren;
    gnt_data = idle && cpu_data && !(inst_first && cpu_inst);
    gnt_inst = idle && cpu_inst && !gnt_data;
    gnt_host = idle && host_req && !cpu_data && !cpu_inst;
    is_wr = (gnt_data && bus.MemWrite) || (gnt_host && bus.host_wren);
    rd_gnt = (gnt_data || gnt_inst || gnt_host) && !is_wr;
    bus.Mem_Req_Ready = gnt_data;
    bus.Inst_Req_Ready = gnt_inst;
    bus.mem_wren = is_wr;
    bus.mem_rden = rd_gnt;
    bus.mem_addr = gnt_data ? bus.Address[MEM_ADDR_WIDTH-1:2] :
                   gnt_inst ? bus.PC[MEM_ADDR_WIDTH-1:2] :
                   gnt_host ? bus.host_addr : '0;
    bus.mem_wdata = !is_wr ? '0 : gnt_data ? bus.Write_data : bus.host_wdata;
    bus.mem_wstrb = !is_wr ? '0 : gnt_data ? bus.Write_strb : 4'hf;
    state_n = state_q;
    if (rd_gnt) state_n = gnt_data ? RESP_DATA : gnt_inst ? RESP_INST : RESP_HOST;
    else if (state_q == RESP_HOST || (state_q == RESP_INST && bus.Inst_Ready) ||
             (state_q == RESP_DATA && bus.Read_data_Ready)) state_n = IDLE;
    // reset drops any pending CPU response; only a host read granted in reset survives
    state_d = (rst && state_n != RESP_HOST) ? IDLE : state_n;
    rdata_d = rd_gnt ? bus.mem_rdata : state_d == IDLE ? '0 : rdata_q;
    bus.Inst_Valid = !rst && state_q == RESP_INST;
    bus.Instruction = bus.Inst_Valid ? rdata_q : '0;
    bus.Read_data_Valid = !rst && state_q == RESP_DATA;
    bus.Read_data = bus.Read_data_Valid ? rdata_q : '0;
    bus.host_rvalid = state_q == RESP_HOST;
    bus.host_rdata = bus.host_rvalid ? rdata_q : '0;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    rdata_q <= rdata_d;
  end
endmodule
